serial_subtractor: RTL

- Bit-serial W-bit unsigned subtractor that computes diff = a - b, one bit per clock, LSB first.
- The per-bit datapath is one full-subtractor cell, built from two half-subtractor stages plus a borrow OR, with the borrow held in a flop between cycles.
- Operands enter and results leave over valid/ready handshakes, so the block drops into a streaming arithmetic datapath.
- It is the sequential consumer of the half-subtractor cell: it chains the cell's diff/borrow over time.

---
 rtl/sub_pkg.sv | 22 ++
 rtl/full_sub_bit.sv | 31 +++
 rtl/serial_subtractor.sv | 114 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the bit-serial subtractor
// Purpose: state encoding, default operand width and a counter-width helper.
// Ports: none (package).
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_W_DEFAULT = 8;

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// rtl/full_sub_bit.sv - combinational one-bit full subtractor
// Purpose: d = a - b - bin for one bit, built from two half-subtractor stages.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First half subtractor: a - b.
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // Second half subtractor: (a - b) - bin.
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial W-bit unsigned subtractor with valid/ready handshakes
// Purpose: computes diff = (a - b) mod 2^W, LSB first, one bit per clock.
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   in_valid   in  operands a/b valid
//   in_ready   out block can accept operands (IDLE)
//   a, b       in  W-bit minuend / subtrahend
//   out_valid  out diff/borrow valid (DONE)
//   out_ready  in  downstream accepts the result
//   diff       out last completed (a - b) mod 2^W
//   borrow     out last completed borrow, 1 iff a < b
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int CW = clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  sh_a;
  logic [W-1:0]  sh_b;
  logic [W-1:0]  res_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  diff_q;
  logic          borrow_q;

  logic          bit_d;
  logic          bit_bout;

  full_sub_bit u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Handshake outputs are pure state decodes, so no input reaches them combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= a;
            sh_b  <= b;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[W-1:1]};
          sh_b  <= {1'b0, sh_b[W-1:1]};
          res_q <= {bit_d, res_q[W-1:1]};
          br_q  <= bit_bout;
          cnt_q <= cnt_q + 1'b1;
          // Publish only the complete word; partial bits stay in res_q.
          if (cnt_q == LAST) begin
            diff_q   <= {bit_d, res_q[W-1:1]};
            borrow_q <= bit_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
